// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the multi-cycle ALU.
// Imported by the decoder/datapath in alu_mc.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles.
// done is high in the final iteration cycle, with product showing the finished low WIDTH bits.
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    count;
    logic             busy;
    logic [WIDTH-1:0] acc_next;

    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign done     = busy && (count == CW'(WIDTH - 1));
    assign product  = acc_next;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            count  <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes: single-cycle ops complete in one cycle,
// MUL runs through the iterative multiplier; the result is held until the consumer takes it.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [3:0]       ALU_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_result,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    localparam int SW = $clog2(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic             accept;
    logic             is_mul;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] diff;
    logic [SW-1:0]    shamt;
    logic             slt;
    logic             sltu;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;

    assign in_ready  = reset_n && (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (ALU_control == OP_MUL);

    assign sum_ext = {1'b0, data1} + {1'b0, data2};
    assign diff    = data1 - data2;
    assign shamt   = data2[SW-1:0];
    assign slt     = $signed(data1) < $signed(data2);
    assign sltu    = data1 < data2;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (ALU_control)
            OP_AND:  alu_res = data1 & data2;
            OP_OR:   alu_res = data1 | data2;
            OP_XOR:  alu_res = data1 ^ data2;
            OP_SLL:  alu_res = data1 << shamt;
            OP_SRL:  alu_res = data1 >> shamt;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, sltu};
            OP_ADD: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (data1[WIDTH-1] == data2[WIDTH-1]) &&
                          (sum_ext[WIDTH-1] != data1[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_c   = sltu;
                alu_v   = (data1[WIDTH-1] != data2[WIDTH-1]) &&
                          (diff[WIDTH-1] != data1[WIDTH-1]);
            end
            default: ;
        endcase
    end

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (accept && is_mul),
        .a       (data1),
        .b       (data2),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = is_mul ? ST_MUL : ST_DONE;
            ST_MUL:  if (mul_done) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Result registers change only when an accepted operation completes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ALU_result <= '0;
            zero       <= 1'b1;
            carry      <= 1'b0;
            overflow   <= 1'b0;
        end else if (accept && !is_mul) begin
            ALU_result <= alu_res;
            zero       <= (alu_res == '0);
            carry      <= alu_c;
            overflow   <= alu_v;
        end else if (state_q == ST_MUL && mul_done) begin
            ALU_result <= mul_product;
            zero       <= (mul_product == '0);
            carry      <= 1'b0;
            overflow   <= 1'b0;
        end
    end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits (minimum 4, power of two).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 data1  input  WIDTH  operand A.
REQ-007 data2  input  WIDTH  operand B, or shift amount for shifts.
REQ-008 ALU_control  input  4  opcode.
REQ-009 out_valid  output  1  result registers hold a valid result.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 ALU_result  output  WIDTH  registered result.
REQ-012 zero  output  1  registered; 1 when ALU_result == 0.
REQ-013 carry  output  1  registered; ADD carry-out, SUB borrow (data1 < data2 unsigned), else 0.
REQ-014 overflow  output  1  registered; signed overflow for ADD/SUB, else 0.

Function
REQ-015 Opcodes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SLT 0111, SLTU 1000, MUL 1001; all others give result 0, flags 0.
REQ-016 Arithmetic modulo 2^WIDTH; MUL returns low WIDTH bits of the product; SLT/SLTU return 1 or 0 zero-extended.
REQ-017 Shift amount = data2[log2(WIDTH)-1:0]; upper bits ignored; SRL fills with zeros.
REQ-018 FSM states IDLE, MUL, DONE; in_ready = 1 only in IDLE.
REQ-019 Request accepted when in_valid && in_ready; operands and opcode captured in that cycle only.
REQ-020 IDLE, accept, non-MUL opcode: result and flags registered, next state DONE (out_valid 1 cycle after acceptance).
REQ-021 IDLE, accept, MUL: next state MUL; iterative shift-add, one multiplier bit per cycle, WIDTH cycles in MUL, then DONE (out_valid WIDTH+1 cycles after acceptance).
REQ-022 DONE: out_valid = 1; ALU_result and flags stable until out_ready; out_valid && out_ready -> IDLE next cycle.
REQ-023 Changes on data1/data2/ALU_control after acceptance have no effect on the in-flight operation.
REQ-024 in_valid while not IDLE is ignored (not queued).
REQ-025 out_ready while out_valid = 0 has no effect.
REQ-026 Result registers not updated except on completion of an accepted operation.

Reset
REQ-027 reset_n = 0 at a rising edge forces IDLE, out_valid 0, ALU_result 0, zero 1, carry 0, overflow 0, iteration counter 0.
REQ-028 Reset mid-MUL or in DONE aborts the operation; no result is presented afterwards.
REQ-029 in_ready = 0 during the cycle reset_n is low; 1 from the first cycle after release.

Structure
REQ-030 Opcode constants and FSM state encodings live in shared package alu_pkg, reused by the decoder.
REQ-031 Iterative multiplier is sub-module alu_mul_iter (start, operands, done, product low WIDTH bits), parametrised by WIDTH.
REQ-032 Single-cycle datapath is combinational inside alu_mc; only results, flags, FSM, and multiplier state are registered.

Verification (WIDTH = 8)
REQ-033 ADD 8'hFF + 8'h01 -> one cycle later out_valid, ALU_result 8'h00, zero 1, carry 1, overflow 0.
REQ-034 SUB 8'h80 - 8'h01 -> ALU_result 8'h7F, overflow 1, carry 0; SLT 8'h80, 8'h01 -> 1; SLTU -> 0.
REQ-035 MUL 8'h0D * 8'h0B -> out_valid exactly 9 cycles after acceptance, ALU_result 8'h8F; in_ready 0 throughout.
REQ-036 SLL 8'h01 by data2 8'h0B -> shift 3 -> 8'h08; opcode 4'b1111 -> ALU_result 0, zero 1.
REQ-037 Result held with out_ready 0 for 5 cycles while inputs toggle -> ALU_result unchanged, out_valid 1; out_ready 1 -> IDLE next cycle.
REQ-038 reset_n low on 4th MUL cycle -> next cycle IDLE, out_valid 0, ALU_result 0; new ADD afterwards completes normally.
